vector_issue_stage: RTL
=======================

Name: vector_issue_stage

Overview:
- Small in-order issue buffer directly upstream of the vector latency control unit.
- Accepts decoded vector instructions from decode via valid/ready.
- At enqueue, computes each instruction's execution latency from its functional-unit class and vector length, and stores it with the instruction.
- Presents the head instruction's latency to the latency control unit, and issues the head to execution only when that unit does not halt.

Parameters:
- MAX_LATENCY, 32, must match the latency control unit; latency width LW = $clog2(MAX_LATENCY).
- DEPTH, 4, buffer entries (power of two, >=2).
- LANES, 4, vector lanes (power of two).
- VL_WIDTH, 7, vector-length field width.
- PAYLOAD_WIDTH, 32, opaque instruction payload width.
- LAT_ALU, 2, base latency of fu class 0.
- LAT_MUL, 4, base latency of fu class 1.
- LAT_DIV, 12, base latency of fu class 2.
- LAT_MEM, 6, base latency of fu class 3.

Ports:
- clock_i  in  1  clock.
- reset_ni  in  1  reset.
- flush_i  in  1  synchronous flush, discards all buffered entries.
- enq_valid_i  in  1  decode has an instruction.
- enq_ready_o  out  1  buffer can accept.
- enq_fu_i  in  2  functional-unit class 0..3.
- enq_vl_i  in  VL_WIDTH  vector length in elements.
- enq_payload_i  in  PAYLOAD_WIDTH  instruction payload.
- exe_ready_i  in  1  execution backend can accept an instruction.
- halt_pipeline_i  in  1  halt from the latency control unit.
- issue_latency_o  out  LW  latency presented to the latency control unit.
- issue_valid_o  out  1  head instruction issues this cycle.
- issue_fu_o  out  2  head fu class.
- issue_payload_o  out  PAYLOAD_WIDTH  head payload.
- occupancy_o  out  $clog2(DEPTH)+1  valid entries.

Interface rule: reset reset_ni, asynchronous, active-low; clock clock_i.

Behaviour:
- Reset state: buffer empty; read/write pointers and count 0. Outputs at reset: occupancy_o=0, enq_ready_o=1, issue_valid_o=0, issue_latency_o=0, issue_fu_o=0, issue_payload_o=0.
- Storage: circular FIFO of DEPTH entries; each entry holds {latency, fu, payload}. Pointers wrap modulo DEPTH.
- Latency at enqueue:
  - lat = BASE[fu] + ceil(vl/LANES).
  - vl=0 contributes 0.
  - Compute at LW+VL_WIDTH bits, then saturate to MAX_LATENCY-1.
  - A result of 0 is forced to 1.
- Enqueue:
  - enq_ready_o = (count < DEPTH) && !flush_i.
  - An entry is written on enq_valid_i && enq_ready_o.
  - No bypass: an entry enqueued in cycle t is visible at the head in t+1 at the earliest.
- Presentation:
  - issue_latency_o = head.latency when (count>0 && exe_ready_i && !flush_i); otherwise 0.
  - A presented 0 never loads the latency control unit.
  - issue_latency_o must not depend on halt_pipeline_i; this avoids a combinational loop, since halt is combinational from latency.
- Issue:
  - issue_valid_o = (count>0) && exe_ready_i && !halt_pipeline_i && !flush_i.
  - On issue_valid_o the head pops at the clock edge.
  - issue_fu_o/issue_payload_o show the head whenever count>0; otherwise 0.
- Halt: while halt_pipeline_i=1 the head is held and re-presented every cycle with the same latency. Enqueue continues until full.
- Simultaneous enqueue and issue: count unchanged, both pointers advance.
- Full: enq_ready_o=0. An issue in the same cycle does not reopen ready until the next cycle.
- Flush:
  - At the edge where flush_i=1: pointers and count return to 0.
  - The same-cycle enqueue is rejected and the same-cycle issue is suppressed.
- Reset mid-operation: all contents discarded immediately (asynchronous); outputs take their reset values.

Optional Feature:
- Macro: VECTOR_ISSUE_PERF_COUNTERS_EN.
- When defined, two extra outputs are present:
  - perf_issued_o (32 bits): increments on every issue_valid_o.
  - perf_halt_cycles_o (32 bits): increments on cycles with count>0 && exe_ready_i && halt_pipeline_i.
  - Both reset to 0, wrap at 2^32, and are not cleared by flush_i.
- When undefined: the ports and counters are absent, and the remaining behaviour is identical.

Test Plan:
- Reset, then idle: occupancy_o=0, enq_ready_o=1, issue_valid_o=0, issue_latency_o=0.
- Enqueue fu=0, vl=8; exe_ready_i=1, halt=0: next cycle issue_latency_o=4 (2+2) and issue_valid_o=1; occupancy then returns to 0.
- Enqueue fu=2, vl=100 (12+25=37): issue_latency_o saturates to 31. Enqueue fu=0, vl=0: latency 2. Enqueue fu=1, vl=3: latency 4+1=5.
- Hold halt_pipeline_i=1 for 3 cycles with one entry: head latency is presented 3 cycles with issue_valid_o=0; issue happens on the first cycle after halt drops.
- Enqueue 5 back-to-back with exe_ready_i=0: accept 4, enq_ready_o=0 on the 5th. Raise exe_ready_i: FIFO order preserved across pointer wrap.
- With 3 entries, assert flush_i together with enq_valid_i: next cycle occupancy_o=0, and nothing issued or enqueued in the flush cycle.

Source files
------------

// File: rtl/vector_issue_stage.sv
// vector_issue_stage: in-order vector issue buffer feeding the latency control unit.
// Optional VECTOR_ISSUE_PERF_COUNTERS_EN adds issue and halt-cycle counters.
module vector_issue_stage #(
  parameter int MAX_LATENCY   = 32,
  parameter int DEPTH         = 4,
  parameter int LANES         = 4,
  parameter int VL_WIDTH      = 7,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int LAT_ALU       = 2,
  parameter int LAT_MUL       = 4,
  parameter int LAT_DIV       = 12,
  parameter int LAT_MEM       = 6
) (
  input  logic                             clock_i,
  input  logic                             reset_ni,
  input  logic                             flush_i,
  input  logic                             enq_valid_i,
  output logic                             enq_ready_o,
  input  logic [1:0]                       enq_fu_i,
  input  logic [VL_WIDTH-1:0]              enq_vl_i,
  input  logic [PAYLOAD_WIDTH-1:0]         enq_payload_i,
  input  logic                             exe_ready_i,
  input  logic                             halt_pipeline_i,
  output logic [$clog2(MAX_LATENCY)-1:0]   issue_latency_o,
  output logic                             issue_valid_o,
  output logic [1:0]                       issue_fu_o,
  output logic [PAYLOAD_WIDTH-1:0]         issue_payload_o,
  output logic [$clog2(DEPTH):0]           occupancy_o
`ifdef VECTOR_ISSUE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                      perf_issued_o,
  output logic [31:0]                      perf_halt_cycles_o
`endif
);

  localparam int LW    = $clog2(MAX_LATENCY);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int CALCW = LW + VL_WIDTH;
  localparam int LSH   = $clog2(LANES);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [LW-1:0]            lat_q [DEPTH];
  logic [1:0]               fu_q  [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] pay_q [DEPTH];
  logic [PW-1:0]            wr_q, rd_q;
  logic [CW-1:0]            cnt_q, cnt_d;

  logic [CALCW-1:0] base_c, chunks_c, sum_c;
  logic [LW-1:0]    lat_c;
  logic             nonempty, enq_fire, present;

  assign nonempty      = (cnt_q != '0);
  assign enq_ready_o   = (cnt_q != FULL_C) && !flush_i;
  assign enq_fire      = enq_valid_i && enq_ready_o;
  assign present       = nonempty && exe_ready_i && !flush_i;
  assign issue_valid_o = present && !halt_pipeline_i;
  assign occupancy_o   = cnt_q;

  // Latency presented to the control unit never looks at halt, avoiding a loop.
  assign issue_latency_o = present  ? lat_q[rd_q] : '0;
  assign issue_fu_o      = nonempty ? fu_q[rd_q]  : '0;
  assign issue_payload_o = nonempty ? pay_q[rd_q] : '0;

  // Enqueue latency: class base plus lane-chunked vl, saturated, never zero.
  always_comb begin
    base_c = '0;
    unique case (enq_fu_i)
      2'd0: base_c = CALCW'(LAT_ALU);
      2'd1: base_c = CALCW'(LAT_MUL);
      2'd2: base_c = CALCW'(LAT_DIV);
      2'd3: base_c = CALCW'(LAT_MEM);
    endcase
    chunks_c = (CALCW'(enq_vl_i) + CALCW'(LANES - 1)) >> LSH;
    sum_c    = base_c + chunks_c;
    if (sum_c > CALCW'(MAX_LATENCY - 1))
      lat_c = LW'(MAX_LATENCY - 1);
    else if (sum_c == '0)
      lat_c = LW'(1);
    else
      lat_c = sum_c[LW-1:0];
  end

  // Occupancy next state from enqueue/issue pair.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({enq_fire, issue_valid_o})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Circular buffer storage and pointers; flush empties it.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        lat_q[i] <= '0;
        fu_q[i]  <= '0;
        pay_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (enq_fire) begin
        lat_q[wr_q] <= lat_c;
        fu_q[wr_q]  <= enq_fu_i;
        pay_q[wr_q] <= enq_payload_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (issue_valid_o)
        rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

`ifdef VECTOR_ISSUE_PERF_COUNTERS_EN
  logic [31:0] issued_q, halted_q;

  assign perf_issued_o      = issued_q;
  assign perf_halt_cycles_o = halted_q;

  // Free-running counters; flush deliberately leaves them alone.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      issued_q <= '0;
      halted_q <= '0;
    end else begin
      if (issue_valid_o)
        issued_q <= issued_q + 32'd1;
      if (nonempty && exe_ready_i && halt_pipeline_i)
        halted_q <= halted_q + 32'd1;
    end
  end
`else
  // Counters absent in this build.
`endif

endmodule
